// File: rtl/mau_pkg.sv
// ============================================================================
// mau_pkg : shared types, memwrite codes and op-decode helpers for
//           mem_access_unit.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mau_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LW  = 4'd2,
    LWU = 4'd3,
    LD  = 4'd4,
    SB  = 4'd8,
    SW  = 4'd9,
    SD  = 4'd10
  } lsu_op_t;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_W    = 2'd1;
  localparam logic [1:0] MW_B    = 2'd2;
  localparam logic [1:0] MW_D    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } st_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      LB, LBU, LW, LWU, LD, SB, SW, SD: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op == SB) || (op == SW) || (op == SD);
  endfunction

  function automatic logic [1:0] store_mw(input logic [3:0] op);
    case (op)
      SB:      return MW_B;
      SW:      return MW_W;
      SD:      return MW_D;
      default: return MW_NONE;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [2:0] lo);
    case (op)
      LW, LWU, SW: return lo[1:0] != 2'b00;
      LD, SD:      return lo != 3'b000;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// load_extract : combinational big-endian lane select and sign/zero extension
//                of a load result.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module load_extract
  import mau_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [3:0]   op,
  input  logic [1:0]   addr_lo,
  input  logic [N-1:0] readdata,
  output logic [N-1:0] rdata
);

  logic [31:0] word;
  logic [7:0]  lane;

  assign word = readdata[31:0];

  // Byte 0 of a word is its most significant lane.
  always_comb begin
    case (addr_lo)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      default: lane = word[7:0];
    endcase
  end

  always_comb begin
    rdata = '0;
    case (op)
      LB:      rdata = {{(N-8){lane[7]}}, lane};
      LBU:     rdata = {{(N-8){1'b0}}, lane};
      LW:      rdata = {{(N-32){word[31]}}, word};
      LWU:     rdata = {{(N-32){1'b0}}, word};
      LD:      rdata = readdata;
      default: rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : single-outstanding load/store initiator for a 64-bit
//                   big-endian data memory. Optional MISALIGN_TRAP_EN macro
//                   traps misaligned word/dword accesses.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mau_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         dword,
  output logic [1:0]   memwrite,
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  input  logic [N-1:0] readdata
);

  st_t          state, next_state;
  logic [3:0]   op_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] rdata_q;
  logic         err_q;

  logic         misalign;
  logic         err_now;
  logic         is_store;
  logic [N-1:0] ext;

`ifdef MISALIGN_TRAP_EN
  assign misalign = op_misaligned(op_q, addr_q[2:0]);
`else
  assign misalign = 1'b0;
`endif

  assign err_now  = !op_legal(op_q) || misalign;
  assign is_store = op_store(op_q);

  load_extract #(.N(N)) u_load_extract (
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .readdata (readdata),
    .rdata    (ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == S_ACCESS) begin
        rdata_q <= (err_now || is_store) ? '0 : ext;
        err_q   <= err_now;
      end
    end
  end

  // memwrite/dword come only from registered state so a reset drops them at once.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    memwrite   = MW_NONE;
    dword      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = S_ACCESS;
      end
      S_ACCESS: begin
        next_state = S_RESP;
        if (is_store && !err_now) memwrite = store_mw(op_q);
        dword = (op_q == LD) && !err_now;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign dataadr   = addr_q;
  assign writedata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : self-checking bench for mem_access_unit with a
//                      big-endian memory and a byte-array reference model.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        dword;
  logic [1:0]  memwrite;
  logic [63:0] dataadr;
  logic [63:0] writedata;
  logic [63:0] readdata;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.N(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dword     (dword),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata)
  );

  always #5 clk = ~clk;

  // Memory serving the DUT: 32 big-endian dwords, comb read, sync write.
  logic [63:0] mem [0:31];
  logic [4:0]  midx;
  assign midx = dataadr[7:3];

  always_comb begin
    if (dword) readdata = mem[midx];
    else       readdata = {32'b0, dataadr[2] ? mem[midx][31:0] : mem[midx][63:32]};
  end

  always @(posedge clk) begin
    case (memwrite)
      2'd1: if (dataadr[2]) mem[midx][31:0] <= writedata[31:0];
            else            mem[midx][63:32] <= writedata[31:0];
      2'd2: mem[midx][63 - 8*dataadr[2:0] -: 8] <= writedata[7:0];
      2'd3: mem[midx] <= writedata;
      default: ;
    endcase
  end

  // Reference model: flat byte array, byte at address a is most significant.
  logic [7:0] ref_b [0:255];

  task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic err, output logic [1:0] mw);
    int ai, base;
    logic trap;
    logic [31:0] w;
    ai = int'(a[7:0]);
    rd = '0; err = 1'b0; mw = 2'd0; trap = 1'b0; w = '0;
`ifdef MISALIGN_TRAP_EN
    if ((op inside {4'd2, 4'd3, 4'd9}) && (ai % 4 != 0)) trap = 1'b1;
    if ((op inside {4'd4, 4'd10}) && (ai % 8 != 0)) trap = 1'b1;
`endif
    if (trap) begin
      err = 1'b1;
    end else begin
      case (op)
        4'd0: rd = {56'b0, ref_b[ai]} | (ref_b[ai][7] ? ~64'hFF : 64'h0);
        4'd1: rd = {56'b0, ref_b[ai]};
        4'd2, 4'd3: begin
          base = ai - ai % 4;
          for (int i = 0; i < 4; i++) w = (w << 8) | 32'(ref_b[base+i]);
          rd = {32'b0, w};
          if (op == 4'd2 && w[31]) rd = rd | 64'hFFFF_FFFF_0000_0000;
        end
        4'd4: begin
          base = ai - ai % 8;
          for (int i = 0; i < 8; i++) rd = (rd << 8) | 64'(ref_b[base+i]);
        end
        4'd8: begin ref_b[ai] = wd[7:0]; mw = 2'd2; end
        4'd9: begin
          base = ai - ai % 4;
          for (int i = 0; i < 4; i++) ref_b[base+i] = wd[31-8*i -: 8];
          mw = 2'd1;
        end
        4'd10: begin
          base = ai - ai % 8;
          for (int i = 0; i < 8; i++) ref_b[base+i] = wd[63-8*i -: 8];
          mw = 2'd3;
        end
        default: err = 1'b1;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; stall = cycles rsp_ready is held low after rsp_valid.
  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] wd,
                       input int stall, output logic [63:0] rd, output logic err,
                       output logic [1:0] mw, output int mwcnt);
    int waited;
    logic bad;
    logic got;
    rd = '0; err = 1'b0; mw = 2'd0; mwcnt = 0; bad = 1'b0; got = 1'b0;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (memwrite != 2'd0) begin
        mwcnt++;
        mw = memwrite;
      end
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 10 cycles");
    end
    rd = rsp_rdata;
    err = rsp_err;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rdata !== rd || rsp_err !== err || req_ready || memwrite != 2'd0)
          bad = 1'b1;
      end
      check("stall_stable", {63'b0, bad}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [1:0]  exp_mw;
  } vec_t;

  vec_t tv [15];

  initial begin
    logic [63:0] rd, mrd, old;
    logic        er, merr;
    logic [1:0]  mw, mmw;
    int          cnt;
    logic [3:0]  ops [10];
    logic [63:0] a;
    logic        mem_ok;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) ref_b[i] = '0;

    tv[0]  = '{4'd10, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 2'd3};
    tv[1]  = '{4'd4,  64'h10, 64'h0, 64'h1122334455667788, 1'b0, 2'd0};
    tv[2]  = '{4'd8,  64'h13, 64'hFF, 64'h0, 1'b0, 2'd2};
    tv[3]  = '{4'd0,  64'h13, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2'd0};
    tv[4]  = '{4'd1,  64'h13, 64'h0, 64'h00000000000000FF, 1'b0, 2'd0};
    tv[5]  = '{4'd9,  64'h14, 64'h80000001, 64'h0, 1'b0, 2'd1};
    tv[6]  = '{4'd2,  64'h14, 64'h0, 64'hFFFFFFFF80000001, 1'b0, 2'd0};
    tv[7]  = '{4'd3,  64'h14, 64'h0, 64'h0000000080000001, 1'b0, 2'd0};
    tv[8]  = '{4'd4,  64'h10, 64'h0, 64'h112233FF80000001, 1'b0, 2'd0};
    tv[9]  = '{4'd1,  64'h10, 64'h0, 64'h0000000000000011, 1'b0, 2'd0};
    tv[10] = '{4'd10, 64'h08, 64'hAABBCCDDEEFF0011, 64'h0, 1'b0, 2'd3};
`ifdef MISALIGN_TRAP_EN
    tv[11] = '{4'd4,  64'h0C, 64'h0, 64'h0, 1'b1, 2'd0};
`else
    tv[11] = '{4'd4,  64'h0C, 64'h0, 64'hAABBCCDDEEFF0011, 1'b0, 2'd0};
`endif
    tv[12] = '{4'hF,  64'h08, 64'h1234, 64'h0, 1'b1, 2'd0};
    tv[13] = '{4'd5,  64'h08, 64'h5678, 64'h0, 1'b1, 2'd0};
    tv[14] = '{4'd4,  64'h08, 64'h0, 64'hAABBCCDDEEFF0011, 1'b0, 2'd0};

    // Reset state
    #12;
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_memwrite", {62'b0, memwrite}, 64'd0);
    check("rst_dword", {63'b0, dword}, 64'd0);
    check("rst_dataadr", dataadr, 64'd0);
    check("rst_writedata", writedata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      do_op(tv[i].op, tv[i].addr, tv[i].wdata, 0, rd, er, mw, cnt);
      model(tv[i].op, tv[i].addr, tv[i].wdata, mrd, merr, mmw);
      check($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
      check($sformatf("tv%0d_err", i), {63'b0, er}, {63'b0, tv[i].exp_err});
      check($sformatf("tv%0d_mw", i), {62'b0, mw}, {62'b0, tv[i].exp_mw});
      check($sformatf("tv%0d_mwcnt", i), 64'(cnt), (tv[i].exp_mw != 2'd0) ? 64'd1 : 64'd0);
      if (i == 2) check("sb_lane", {56'b0, mem[2][39:32]}, 64'hFF);
    end

    // Response held while consumer stalls
    do_op(4'd4, 64'h10, 64'h0, 5, rd, er, mw, cnt);
    check("stall_rdata", rd, 64'h112233FF80000001);

    // Reset during S_ACCESS of a store
    old = mem[3];
    @(negedge clk);
    req_op = 4'd10; req_addr = 64'h18; req_wdata = 64'hDEADBEEFCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rstmid_mw_before", {62'b0, memwrite}, 64'd3);
    #2 reset_n = 1'b0;
    #1 check("rstmid_mw_drop", {62'b0, memwrite}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_mem", mem[3], old);
    check("rstmid_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rstmid_req_ready", {63'b0, req_ready}, 64'd1);

    // Randomized traffic vs reference model
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd9, 4'd10};
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [63:0] wd;
      op = ($urandom_range(0, 19) == 0) ? 4'(16'($urandom_range(5, 7))) : ops[$urandom_range(0, 9)];
      a  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      wd = {$urandom, $urandom};
      do_op(op, a, wd, 0, rd, er, mw, cnt);
      model(op, a, wd, mrd, merr, mmw);
      check($sformatf("rnd%0d_rdata", n), rd, mrd);
      check($sformatf("rnd%0d_err", n), {63'b0, er}, {63'b0, merr});
      check($sformatf("rnd%0d_mw", n), {62'b0, mw}, {62'b0, mmw});
    end

    mem_ok = 1'b1;
    for (int i = 0; i < 256; i++)
      if (mem[i/8][63 - 8*(i%8) -: 8] !== ref_b[i]) mem_ok = 1'b0;
    check("final_mem", {63'b0, mem_ok}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
